// File: rtl/pipe_mem.sv
// pipe_mem: hxd32 memory-access stage; ALU pass-through plus one outstanding data-bus
// transaction with byte-lane alignment, load extension and misalignment detection.
module pipe_mem #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   alu_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [2:0]        mem_funct3_i,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              valid_o,
  output logic [XLEN-1:0]   rd_wr_data_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [XLEN-1:0]   dbus_addr_o,
  output logic [XLEN/8-1:0] dbus_be_o,
  output logic [XLEN-1:0]   dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [XLEN-1:0]   dbus_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e state_q;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic mem_op, is_st, mis;
  logic [1:0] off;
  logic [XLEN/8-1:0] be_d;
  logic [XLEN-1:0] wdata_d, sh, ld_data;
  assign off = alu_data_i[1:0];
  assign mem_op = mem_rd_en_i | mem_wr_en_i;
  // a simultaneous load+store request from decode is handled as a load
  assign is_st = mem_wr_en_i & ~mem_rd_en_i;
  always_comb begin
    mis = (mem_funct3_i[1:0] == 2'b01) ? off[0] : mem_funct3_i[1] ? |off : 1'b0;
    be_d = (mem_funct3_i[1:0] == 2'b00) ? 4'b0001 << off :
           (mem_funct3_i[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
    wdata_d = (mem_funct3_i[1:0] == 2'b00) ? {4{rs2_data_i[7:0]}} :
              (mem_funct3_i[1:0] == 2'b01) ? {2{rs2_data_i[15:0]}} : rs2_data_i;
    sh = dbus_rdata_i >> {off_q, 3'b000};
    ld_data = (f3_q[1:0] == 2'b00) ? {{(XLEN-8){sh[7] & ~f3_q[2]}}, sh[7:0]} :
              (f3_q[1:0] == 2'b01) ? {{(XLEN-16){sh[15] & ~f3_q[2]}}, sh[15:0]} : dbus_rdata_i;
    stall_o = (state_q == IDLE) ? valid_i & mem_op & ~mis : (state_q == REQ) | ~dbus_rvalid_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      off_q        <= '0;
      f3_q         <= '0;
      misalign_o   <= 1'b0;
      valid_o      <= 1'b0;
      rd_wr_data_o <= '0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: if (valid_i) begin
          if (!mem_op) begin
            rd_wr_data_o <= alu_data_i;
            valid_o      <= 1'b1;
          end else if (mis) begin
            misalign_o <= 1'b1;
          end else begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_st;
            dbus_addr_o  <= {alu_data_i[XLEN-1:2], 2'b00};
            dbus_be_o    <= be_d;
            dbus_wdata_o <= wdata_d;
            f3_q         <= mem_funct3_i;
            off_q        <= off;
            state_q      <= REQ;
          end
        end
        REQ: if (dbus_gnt_i) begin
          dbus_req_o <= 1'b0;
          state_q    <= RESP;
        end
        default: if (dbus_rvalid_i) begin
          state_q <= IDLE;
          if (!dbus_we_o) begin
            rd_wr_data_o <= ld_data;
            valid_o      <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: scoreboard bench for pipe_mem; expected write-back values are queued at issue
// and popped whenever valid_o is seen.
module tb_pipe_mem;
  logic        clk_i = 0, rst_i = 1;
  logic        valid_i = 0, mem_rd_en_i = 0, mem_wr_en_i = 0;
  logic [31:0] alu_data_i = 0, rs2_data_i = 0, dbus_rdata_i = 0;
  logic [2:0]  mem_funct3_i = 0;
  logic        stall_o, misalign_o, valid_o, dbus_req_o, dbus_we_o;
  logic [31:0] rd_wr_data_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i = 0, dbus_rvalid_i = 0;
  int checks = 0, errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd = 0;

  pipe_mem #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_data_i(alu_data_i),
    .rs2_data_i(rs2_data_i), .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .mem_funct3_i(mem_funct3_i), .stall_o(stall_o), .misalign_o(misalign_o),
    .valid_o(valid_o), .rd_wr_data_o(rd_wr_data_o), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("rd_data", rd_wr_data_o, sb_q.pop_front());
      last_rd = rd_wr_data_o;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, {31'd0, dbus_req_o}, 0);
    check({tag, "_valid"}, {31'd0, valid_o}, 0);
    check({tag, "_mis"}, {31'd0, misalign_o}, 0);
    check({tag, "_rd"}, rd_wr_data_o, 0);
    check({tag, "_we"}, {31'd0, dbus_we_o}, 0);
    check({tag, "_addr"}, dbus_addr_o, 0);
    check({tag, "_be"}, {28'd0, dbus_be_o}, 0);
    check({tag, "_wdata"}, dbus_wdata_o, 0);
    check({tag, "_stall"}, {31'd0, stall_o}, 0);
  endtask

  task automatic alu_op(input logic [31:0] d);
    valid_i = 1; mem_rd_en_i = 0; mem_wr_en_i = 0; alu_data_i = d;
    sb_q.push_back(d);
    @(negedge clk_i); check("alu_stall", {31'd0, stall_o}, 0);
    @(posedge clk_i); #1; valid_i = 0;
    @(negedge clk_i); check("alu_valid", {31'd0, valid_o}, 1);
    @(posedge clk_i); #1;
  endtask

  // issues one load/store, answers with gnt after wait_g and rvalid after wait_r extra cycles
  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int wait_g, input int wait_r,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
    valid_i = 1; mem_rd_en_i = ld; mem_wr_en_i = !ld; mem_funct3_i = f3; alu_data_i = a; rs2_data_i = d;
    if (ld) sb_q.push_back(exp);
    @(negedge clk_i); check("issue_stall", {31'd0, stall_o}, 1);
    @(posedge clk_i); #1;
    for (int i = 0; i <= wait_g; i++) begin
      dbus_gnt_i = (i == wait_g);
      @(negedge clk_i);
      check("req", {31'd0, dbus_req_o}, 1);
      check("we", {31'd0, dbus_we_o}, {31'd0, !ld});
      check("addr", dbus_addr_o, {a[31:2], 2'b00});
      check("be", {28'd0, dbus_be_o}, {28'd0, be});
      if (!ld) check("wdata", dbus_wdata_o, wd);
      check("req_stall", {31'd0, stall_o}, 1);
      @(posedge clk_i); #1;
    end
    dbus_gnt_i = 0;
    for (int i = 0; i <= wait_r; i++) begin
      dbus_rvalid_i = (i == wait_r); dbus_rdata_i = rdata;
      @(negedge clk_i);
      check("resp_req", {31'd0, dbus_req_o}, 0);
      check("resp_stall", {31'd0, stall_o}, {31'd0, i != wait_r});
      @(posedge clk_i); #1;
    end
    dbus_rvalid_i = 0; valid_i = 0; mem_rd_en_i = 0; mem_wr_en_i = 0;
    @(negedge clk_i);
    check("done_valid", {31'd0, valid_o}, {31'd0, ld});
    if (!ld) check("st_rd_keep", rd_wr_data_o, last_rd);
    @(posedge clk_i); #1;
  endtask

  task automatic misalign_op(input logic ld, input logic [2:0] f3, input logic [31:0] a);
    valid_i = 1; mem_rd_en_i = ld; mem_wr_en_i = !ld; mem_funct3_i = f3; alu_data_i = a;
    @(negedge clk_i); check("mis_stall", {31'd0, stall_o}, 0);
    @(posedge clk_i); #1; valid_i = 0; mem_rd_en_i = 0; mem_wr_en_i = 0;
    @(negedge clk_i);
    check("mis_pulse", {31'd0, misalign_o}, 1);
    check("mis_req", {31'd0, dbus_req_o}, 0);
    check("mis_valid", {31'd0, valid_o}, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i); check("mis_clear", {31'd0, misalign_o}, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #3 check_idle_outputs("reset");
    @(posedge clk_i); #1; rst_i = 0;
    @(posedge clk_i); #1;
    alu_op(32'h12345678);
    alu_op(32'hA5A5_0001);
    mem_op(1, 3'b000, 32'h103, 0, 32'h80FFFFFF, 0, 0, 4'b1000, 0, 32'hFFFFFF80);
    mem_op(1, 3'b101, 32'h202, 0, 32'hBEEF0000, 2, 0, 4'b1100, 0, 32'h0000BEEF);
    mem_op(0, 3'b000, 32'h301, 32'h000000A5, 0, 0, 0, 4'b0010, 32'hA5A5A5A5, 0);
    mem_op(1, 3'b001, 32'h102, 0, 32'h80011234, 0, 1, 4'b1100, 0, 32'hFFFF8001);
    mem_op(1, 3'b100, 32'h101, 0, 32'h00009A00, 1, 0, 4'b0010, 0, 32'h0000009A);
    mem_op(1, 3'b010, 32'h040, 0, 32'hCAFEF00D, 0, 2, 4'b1111, 0, 32'hCAFEF00D);
    mem_op(0, 3'b001, 32'h002, 32'h1234ABCD, 0, 0, 0, 4'b1100, 32'hABCDABCD, 0);
    mem_op(0, 3'b010, 32'h010, 32'hDEADBEEF, 0, 1, 1, 4'b1111, 32'hDEADBEEF, 0);
    mem_op(1, 3'b011, 32'h020, 0, 32'h87654321, 0, 0, 4'b1111, 0, 32'h87654321);
    misalign_op(1, 3'b010, 32'h402);
    misalign_op(0, 3'b001, 32'h403);
    misalign_op(1, 3'b101, 32'h001);
    // abandon a load in RESP with reset, then feed a stale response
    valid_i = 1; mem_rd_en_i = 1; mem_funct3_i = 3'b010; alu_data_i = 32'h500;
    @(posedge clk_i); #1; dbus_gnt_i = 1;
    @(posedge clk_i); #1; dbus_gnt_i = 0; valid_i = 0; mem_rd_en_i = 0;
    rst_i = 1; last_rd = 0;
    #1 check_idle_outputs("midrst");
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1; dbus_rvalid_i = 1; dbus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk_i); check("stale_stall", {31'd0, stall_o}, 0);
    @(posedge clk_i); #1; dbus_rvalid_i = 0;
    @(negedge clk_i);
    check("stale_valid", {31'd0, valid_o}, 0);
    check("stale_req", {31'd0, dbus_req_o}, 0);
    check("stale_rd", rd_wr_data_o, 0);
    @(posedge clk_i); #1;
    alu_op(32'h0BADF00D);
    repeat (2) @(posedge clk_i);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pipe_mem.md
Name: pipe_mem

Overview:
- Memory-access stage of the hxd32 pipeline, between execute and writeback.
- Non-memory instructions pass their execute result through with 1-cycle latency.
- Loads and stores run one single-outstanding transaction on the data bus, stalling upstream until it completes.
- Produces the rd write-back value consumed by the writeback stage; handles byte-lane alignment, load sign/zero extension and misalignment detection.

Parameters:
- XLEN, 32, datapath width; only 32 is supported (4 byte lanes).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  execute stage presents an instruction
- alu_data_i  in  XLEN  execute result; effective address for loads/stores
- rs2_data_i  in  XLEN  store source data
- mem_rd_en_i  in  1  instruction is a load
- mem_wr_en_i  in  1  instruction is a store
- mem_funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- stall_o  out  1  upstream must hold all inputs (combinational)
- misalign_o  out  1  registered 1-cycle misaligned-access pulse
- valid_o  out  1  rd_wr_data_o carries a result this cycle
- rd_wr_data_o  out  XLEN  value for writeback
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dbus_be_o  out  XLEN/8  byte enables
- dbus_wdata_o  out  XLEN  lane-replicated store data
- dbus_gnt_i  in  1  request accepted (on dbus_req_o & dbus_gnt_i)
- dbus_rvalid_i  in  1  response/ack
- dbus_rdata_i  in  XLEN  read data

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0, including rd_wr_data_o, dbus_*, valid_o and misalign_o.
- FSM states: IDLE, REQ, RESP.
- IDLE, valid_i=0: valid_o<=0.
- IDLE, valid_i with no mem op: rd_wr_data_o<=alu_data_i, valid_o<=1, stall_o=0.
- IDLE, valid_i with mem op:
  - Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0): no bus access, misalign_o<=1 for 1 cycle, valid_o<=0, stall_o=0.
  - Otherwise: stall_o=1; register addr, be, wdata, we, funct3 and addr[1:0]; dbus_req_o<=1; go REQ; valid_o<=0.
- REQ: hold all dbus_* stable; stall_o=1; valid_o<=0. On dbus_gnt_i: dbus_req_o<=0, go RESP.
- RESP, no dbus_rvalid_i: stall_o=1; valid_o<=0.
- RESP, dbus_rvalid_i: stall_o=0 (same cycle, so upstream advances); go IDLE.
  - Load: rd_wr_data_o<=extracted data, valid_o<=1.
  - Store: valid_o<=0, rd_wr_data_o unchanged.
- dbus_rvalid_i is ignored in IDLE and REQ, including stale responses after reset.
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
- Store data: B {4{rs2[7:0]}}; H {2{rs2[15:0]}}; W rs2.
- Load extraction: shift dbus_rdata_i right by 8*addr[1:0], then extend.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: unchanged.
- funct3[1:0]=11: treated as word access, no extension.
- mem_rd_en_i and mem_wr_en_i both 1 (illegal from decode): treated as load.
- Minimum memory latency, issue cycle to valid_o: 3 edges (issue, gnt same cycle as req, rvalid the next cycle).
- Reset mid-transaction returns to IDLE immediately with dbus_req_o=0; the abandoned bus response is ignored.

Test Plan:
- ALU pass-through: valid_i=1, no mem op, alu_data_i=0x12345678 -> next cycle valid_o=1, rd_wr_data_o=0x12345678, stall_o never 1.
- LB signed: addr=0x103, rdata=0x80FFFFFF, gnt and rvalid at earliest -> dbus_addr_o=0x100, be=1000, rd_wr_data_o=0xFFFFFF80, valid_o 3 edges after issue.
- LHU with 2 gnt-wait cycles: addr=0x202, rdata=0xBEEF0000 -> req held stable 3 cycles, stall_o=1 throughout, rd_wr_data_o=0x0000BEEF.
- SB: addr=0x301, rs2=0x000000A5 -> we=1, be=0010, wdata=0xA5A5A5A5; on rvalid valid_o=0, stall_o drops.
- Misaligned LW at addr=0x402 -> misalign_o pulses 1 cycle, dbus_req_o stays 0, stall_o=0.
- rst_i asserted in RESP, then a stale rvalid arrives -> all outputs 0, rvalid ignored, next ALU op passes normally.
